// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard control: operand forwarding, stage conditions, multicycle sequencer
module pipe_hazard_ctrl #(
  parameter int AW     = 7,
  parameter int DW     = 32,
  parameter int NWB    = 3,
  parameter int MC_LAT = 4,
  parameter int SCW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_stall,
  input  logic [2*AW-1:0]         src_addr,
  input  logic [1:0]              src_valid,
  input  logic [2*DW-1:0]         rf_data,
  input  logic [NWB*AW-1:0]       prod_addr,
  input  logic [NWB-1:0]          prod_wen,
  input  logic [NWB-1:0]          prod_rdy,
  input  logic [NWB*DW-1:0]       prod_data,
  input  logic                    mc_start,
  input  logic                    redirect,
  output logic [2*DW-1:0]         fwd_data,
  output logic [1:0]              fwd_hit,
  output logic [2*(NWB+2)-1:0]    cond,
  output logic                    mc_busy,
  output logic                    mc_done,
  output logic [SCW-1:0]          stall_cnt
);

  localparam int CW = ($clog2(MC_LAT) > 3) ? $clog2(MC_LAT) : 3;

  localparam logic [1:0] C_RUN    = 2'b00;
  localparam logic [1:0] C_HOLD   = 2'b01;
  localparam logic [1:0] C_BUBBLE = 2'b10;

  typedef enum logic {ST_RUN, ST_MC_BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    slot_lu;
  logic          lu;

  // Scan oldest to youngest so the youngest match is the last one written and wins.
  always_comb begin
    fwd_data = rf_data;
    fwd_hit  = '0;
    slot_lu  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = NWB - 1; k >= 0; k--) begin
        if (src_valid[s] && (src_addr[s*AW +: AW] != '0) && prod_wen[k] &&
            (prod_addr[k*AW +: AW] == src_addr[s*AW +: AW])) begin
          fwd_hit[s]           = prod_rdy[k];
          slot_lu[s]           = ~prod_rdy[k];
          fwd_data[s*DW +: DW] = prod_rdy[k] ? prod_data[k*DW +: DW] : rf_data[s*DW +: DW];
        end
      end
    end
    lu = |slot_lu;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mc_done  = 1'b0;
    if (!cpu_stall) begin
      case (state)
        ST_RUN: begin
          if (mc_start) begin
            state_nx = ST_MC_BUSY;
            cnt_nx   = CW'(MC_LAT - 1);
          end
        end
        ST_MC_BUSY: begin
          if (cnt == '0) begin
            state_nx = ST_RUN;
            mc_done  = 1'b1;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  // A redirect that loses to a hold is simply not applied; ID still holds it and re-presents it.
  always_comb begin
    cond = '0;
    for (int i = 0; i < NWB + 2; i++) begin
      if (!rst) begin
        cond[2*i +: 2] = C_BUBBLE;
      end else if (cpu_stall) begin
        cond[2*i +: 2] = C_HOLD;
      end else if (state == ST_MC_BUSY) begin
        if (i <= 2)      cond[2*i +: 2] = C_HOLD;
        else if (i == 3) cond[2*i +: 2] = C_BUBBLE;
        else             cond[2*i +: 2] = C_RUN;
      end else if (lu) begin
        if (i <= 1)      cond[2*i +: 2] = C_HOLD;
        else if (i == 2) cond[2*i +: 2] = C_BUBBLE;
        else             cond[2*i +: 2] = C_RUN;
      end else if (redirect && i == 0) begin
        cond[2*i +: 2] = C_BUBBLE;
      end else begin
        cond[2*i +: 2] = C_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!cpu_stall && (state == ST_MC_BUSY || lu) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + SCW'(1);
      end
    end
  end

  assign mc_busy = (state == ST_MC_BUSY);

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the CPU's fixed 5-stage flow-control unit.
- Generalised to NWB producer stages behind decode, two decode source operands, and a multicycle-unit (mul/div) busy sequencer with configurable latency.
- Generates per-stage pipeline conditions (run/hold/bubble) and combinational operand forwarding.
- Sits beside the IF/ID/EX/MEM/WB stages in the top-level dataflow; each stage consumes its own 2-bit condition field.

Parameters:
- AW, 7, flow-address width (GPR + HI/LO/CP0 space); address 0 never forwards.
- DW, 32, data width.
- NWB, 3, number of producer stages after ID; index 0 is youngest (EX).
- MC_LAT, 4, multicycle-unit latency in cycles; must be ≥ 2.
- SCW, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cpu_stall  in  1  external freeze
- src_addr  in  2*AW  ID source addresses; slot 1 in the upper AW bits
- src_valid  in  2  source slot in use
- rf_data  in  2*DW  register-file read data per slot
- prod_addr  in  NWB*AW  destination address per producer stage
- prod_wen  in  NWB  producer will write
- prod_rdy  in  NWB  producer data available at this stage (0 = load still in flight)
- prod_data  in  NWB*DW  producer result
- mc_start  in  1  EX starts a multicycle op
- redirect  in  1  ID taken branch/jump/eret
- fwd_data  out  2*DW  resolved operand per slot
- fwd_hit  out  2  slot was forwarded
- cond  out  2*(NWB+2)  stage conditions; stage 0 = IF, 1 = ID, 2..NWB+1 = producers
- mc_busy  out  1  multicycle sequencer active
- mc_done  out  1  one-cycle pulse on completion
- stall_cnt  out  SCW  count of load-use + multicycle stall cycles

Behaviour:
- Reset is asynchronous and active-low on rst.
  - While rst = 0: state = RUN, counter = 0, mc_busy = 0, mc_done = 0, stall_cnt = 0, every cond field = 10 (bubble).
- Cond encoding: 00 run (advance), 01 hold (registers keep value), 10 bubble (load NOP), 11 unused (never driven).
- Forwarding (combinational, per slot):
  - A slot matches producer k when: src_valid set, src_addr ≠ 0, prod_wen[k] = 1, prod_addr[k] == src_addr.
  - The lowest-index (youngest) matching k wins.
  - If the winner has prod_rdy[k] = 1: fwd_data = prod_data[k], fwd_hit = 1.
  - Otherwise fwd_data = rf_data for that slot, fwd_hit = 0.
  - A winner with prod_rdy[k] = 0 raises load-use hazard (lu). Older ready matches never override a younger non-ready match.
- State machine: RUN and MC_BUSY; a 3-bit-or-wider down-counter cnt.
  - RUN → MC_BUSY when mc_start = 1 and cpu_stall = 0; cnt <= MC_LAT-1.
  - In MC_BUSY with cpu_stall = 0: if cnt == 0, go to RUN and pulse mc_done for 1 cycle; else cnt decrements.
  - cpu_stall = 1 freezes state, cnt and stall_cnt.
  - mc_start while in MC_BUSY is ignored.
- Condition priority, highest first:
  - cpu_stall: all fields 01.
  - MC_BUSY: IF, ID, stage 2 = 01; stage 3 = 10; stages > 3 = 00.
  - lu in RUN: IF, ID = 01; stage 2 = 10; rest 00.
  - redirect: IF = 10; rest 00.
  - Otherwise all 00.
  - A redirect coinciding with lu or MC_BUSY is dropped; ID re-presents it after the hold.
- mc_busy = (state == MC_BUSY), registered.
- stall_cnt increments by 1 on each cycle where cpu_stall = 0 and (MC_BUSY or lu); it saturates at all-ones.
- With NWB = 1 there is no stage 3; the MC_BUSY bubble is then applied to no stage.

Test Plan:
- Release rst after 3 cycles; observe cond during reset, then idle → cond = all 10 during reset, all 00 after release, stall_cnt = 0, mc_done = 0.
- src_addr slot0 = 5; prod_addr = {5, 5, 9}, prod_wen = 3'b011, prod_rdy = 3'b111, prod_data[0] = 0xAAAA0000, prod_data[1] = 0x1 → fwd_data slot0 = 0xAAAA0000, fwd_hit[0] = 1. Repeat with src_addr = 0 → fwd_hit = 0, rf_data passed.
- Load-use: slot1 = 7 matches prod 0 with prod_rdy[0] = 0 → cond IF = 01, ID = 01, EX = 10, MEM/WB = 00; stall_cnt +1 per cycle. Raise prod_rdy → all 00 next evaluation.
- mc_start for 1 cycle, MC_LAT = 4 → mc_busy high exactly 4 cycles, mc_done pulses on the 4th, cond IF/ID/EX = 01 and MEM = 10 throughout; stall_cnt = 4.
- cpu_stall asserted for 2 cycles mid-MC_BUSY → all conds 01, cnt frozen; mc_busy lasts 6 cycles total, stall_cnt = 4.
- redirect together with lu → IF held (01), not bubbled. redirect alone → IF = 10, others 00. Assert rst mid-MC_BUSY → immediate return to RUN, mc_busy = 0, stall_cnt = 0.
